// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions: widths, reset PC, NOP encoding, queue entry and state types.
package fetch_unit_pkg;

    localparam int unsigned XLEN_DEFAULT     = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] PC_STEP          = 32'd4;

    typedef struct packed {
        logic        misalign;
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        FS_FETCH,
        FS_MISALIGN,
        FS_HALT
    } fetch_state_t;

    function automatic logic [31:0] pc_step(input logic [31:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry circular FIFO of fetched {misalign, pc, instr} entries with synchronous flush.
module fetch_queue
    import fetch_unit_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    output fetch_entry_t head,
    output logic         head_valid,
    output logic [1:0]   count
);

    fetch_entry_t mem [0:1];
    logic         rd_ptr;
    logic         wr_ptr;
    logic         do_push;
    logic         do_pop;

    always_comb begin
        do_pop  = pop & (count != 2'd0) & ~flush;
        do_push = push & ~flush & ((count != 2'd2) | do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: head is only observed while count is non-zero.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_entry;
    end

    assign head       = mem[rd_ptr];
    assign head_valid = (count != 2'd0);

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC register, instr_mem addressing, redirect handling, 2-entry queue to decode.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirect emits one marker entry then halts fetch.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned XLEN     = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_instr,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc_plus4,
    output logic            if_misalign
);

    logic [31:0]  pc;
    logic [31:0]  pc_next;
    logic [31:0]  target;
    logic         enq;
    logic         pop;
    logic         space;
    fetch_entry_t enq_entry;
    fetch_entry_t head;
    logic         head_valid;
    logic [1:0]   count;

`ifdef FETCH_MISALIGN_TRAP_EN
    fetch_state_t state;
    fetch_state_t state_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FS_FETCH;
        else     state <= state_next;
    end

    always_comb begin
        pop        = if_valid & if_ready;
        space      = (count != 2'd2) | pop;
        target     = redirect_pc;
        state_next = state;
        enq        = 1'b0;
        enq_entry  = '{misalign: 1'b0, pc: pc, instr: imem_instr};
        pc_next    = pc;
        if (redirect_valid) begin
            pc_next    = target;
            state_next = (target[1:0] != 2'b00) ? FS_MISALIGN : FS_FETCH;
        end else begin
            case (state)
                FS_FETCH: begin
                    enq = space;
                    if (space) pc_next = pc_step(pc);
                end
                // PC stays on the bad target so the marker carries it as if_pc.
                FS_MISALIGN: begin
                    enq       = space;
                    enq_entry = '{misalign: 1'b1, pc: pc, instr: NOP_INSTR};
                    if (space) state_next = FS_HALT;
                end
                default: ;
            endcase
        end
    end
`else
    always_comb begin
        pop       = if_valid & if_ready;
        space     = (count != 2'd2) | pop;
        target    = redirect_pc & ~32'd3;
        enq       = ~redirect_valid & space;
        enq_entry = '{misalign: 1'b0, pc: pc, instr: imem_instr};
        pc_next   = pc;
        if (redirect_valid) pc_next = target;
        else if (enq)       pc_next = pc_step(pc);
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pc <= RESET_PC;
        else     pc <= pc_next;
    end

    fetch_queue u_queue (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect_valid),
        .push       (enq),
        .push_entry (enq_entry),
        .pop        (pop),
        .head       (head),
        .head_valid (head_valid),
        .count      (count)
    );

    assign imem_addr   = pc;
    assign if_valid    = head_valid;
    assign if_pc       = head_valid ? head.pc : '0;
    assign if_instr    = head_valid ? head.instr : '0;
    assign if_pc_plus4 = head_valid ? pc_step(head.pc) : '0;
    // Without the trap option the stored misalign bit is always pushed as 0.
    assign if_misalign = head_valid & head.misalign;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; a second instance with RESET_PC=FFFF_FFF8 exercises PC wrap.
module tb_fetch_unit;

    localparam logic [31:0] KEY = 32'hDEAD_0000;

    logic        clk = 1'b0;
    logic        rst, rv, ready;
    logic [31:0] rpc, imem_addr, imem_instr, if_pc, if_instr, if_pc_plus4;
    logic        if_valid, if_misalign;

    logic        rst_w, rv_w, ready_w;
    logic [31:0] rpc_w, imem_addr_w, imem_instr_w, if_pc_w, if_instr_w, if_pc_plus4_w;
    logic        if_valid_w, if_misalign_w;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign imem_instr   = imem_addr ^ KEY;
    assign imem_instr_w = imem_addr_w ^ KEY;

    fetch_unit dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_instr(imem_instr),
        .redirect_valid(rv), .redirect_pc(rpc), .if_valid(if_valid), .if_ready(ready),
        .if_pc(if_pc), .if_instr(if_instr), .if_pc_plus4(if_pc_plus4), .if_misalign(if_misalign)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
        .clk(clk), .rst(rst_w), .imem_addr(imem_addr_w), .imem_instr(imem_instr_w),
        .redirect_valid(rv_w), .redirect_pc(rpc_w), .if_valid(if_valid_w), .if_ready(ready_w),
        .if_pc(if_pc_w), .if_instr(if_instr_w), .if_pc_plus4(if_pc_plus4_w),
        .if_misalign(if_misalign_w)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; rv = 1'b0; rpc = '0; ready = 1'b1;
        rst_w = 1'b1; rv_w = 1'b0; rpc_w = '0; ready_w = 1'b1;
        tick();
        tick();

        check("rst_valid", {31'b0, if_valid}, 32'd0);
        check("rst_pc", if_pc, 32'd0);
        check("rst_instr", if_instr, 32'd0);
        check("rst_plus4", if_pc_plus4, 32'd0);
        check("rst_mis", {31'b0, if_misalign}, 32'd0);
        check("rst_addr", imem_addr, 32'd0);
        check("rstw_valid", {31'b0, if_valid_w}, 32'd0);
        check("rstw_addr", imem_addr_w, 32'hFFFF_FFF8);

        // streaming, one entry per cycle
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("str_valid", {31'b0, if_valid}, 32'd1);
            check("str_pc", if_pc, 32'(4 * i));
            check("str_instr", if_instr, 32'(4 * i) ^ KEY);
            check("str_plus4", if_pc_plus4, 32'(4 * i + 4));
        end

        // backpressure from reset: queue fills at 2, PC stops at 8
        rst = 1'b1;
        tick();
        ready = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid", {31'b0, if_valid}, 32'd1);
            check("bp_pc", if_pc, 32'd0);
            check("bp_instr", if_instr, KEY);
        end
        check("bp_addr", imem_addr, 32'd8);

        // redirect with queue full
        rv = 1'b1; rpc = 32'h100;
        tick();
        check("rd_valid", {31'b0, if_valid}, 32'd0);
        check("rd_addr", imem_addr, 32'h100);
        rv = 1'b0; ready = 1'b1;
        tick();
        check("rd_pc0", if_pc, 32'h100);
        check("rd_instr0", if_instr, 32'h100 ^ KEY);
        tick();
        check("rd_pc1", if_pc, 32'h104);

        // back-to-back redirects: last wins
        rv = 1'b1; rpc = 32'h200;
        tick();
        rpc = 32'h300;
        tick();
        check("b2b_valid", {31'b0, if_valid}, 32'd0);
        rv = 1'b0;
        tick();
        check("b2b_pc", if_pc, 32'h300);

        // asynchronous reset mid-stream with one entry held
        rst = 1'b1;
        #1;
        check("ar_valid", {31'b0, if_valid}, 32'd0);
        check("ar_pc", if_pc, 32'd0);
        check("ar_addr", imem_addr, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("ar_pc0", if_pc, 32'd0);
        tick();
        check("ar_pc1", if_pc, 32'd4);

        // misaligned redirect target
        rv = 1'b1; rpc = 32'h102;
        tick();
        rv = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        check("ma_addr", imem_addr, 32'h102);
        tick();
        check("ma_valid", {31'b0, if_valid}, 32'd1);
        check("ma_flag", {31'b0, if_misalign}, 32'd1);
        check("ma_pc", if_pc, 32'h102);
        check("ma_instr", if_instr, 32'h0000_0013);
        check("ma_plus4", if_pc_plus4, 32'h106);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ma_halt", {31'b0, if_valid}, 32'd0);
        end
        check("ma_haddr", imem_addr, 32'h102);
        rv = 1'b1; rpc = 32'h200;
        tick();
        rv = 1'b0;
        tick();
        check("ma_rpc", if_pc, 32'h200);
        check("ma_rflag", {31'b0, if_misalign}, 32'd0);
`else
        check("ma_addr", imem_addr, 32'h100);
        tick();
        check("ma_pc", if_pc, 32'h100);
        check("ma_flag", {31'b0, if_misalign}, 32'd0);
`endif

        // PC wrap on the second instance
        rst_w = 1'b0;
        tick();
        check("wr_pc0", if_pc_w, 32'hFFFF_FFF8);
        check("wr_p40", if_pc_plus4_w, 32'hFFFF_FFFC);
        tick();
        check("wr_pc1", if_pc_w, 32'hFFFF_FFFC);
        check("wr_p41", if_pc_plus4_w, 32'h0000_0000);
        tick();
        check("wr_pc2", if_pc_w, 32'h0000_0000);
        check("wr_p42", if_pc_plus4_w, 32'h0000_0004);
        check("wr_mis", {31'b0, if_misalign_w}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
